dma_pcie_crdt_arb: RTL and testbench
====================================

# dma_pcie_crdt_arb

Credit-based arbiter that shares one DMA-to-PCIe transmit channel among up to 2**CH_BITS requesters. Each requester maps to one credit channel. The block keeps a credit counter per channel and grants round-robin among requesters that have data and at least one credit. It drives the tl_tdata/tl_tvld/tl_tch transmit side and consumes the tl_crdt/tl_crdt_ch credit-return side of the DMA/PCIe credit interface.

## Interface
Parameters:
- DATA_BITS, 512, beat width
- CH_BITS, 2, channel index width; N_CH = 2**CH_BITS
- CNT_BITS, 8, credit counter width
- CRDT_INIT, 16, per-channel credit count after reset; must be ≤ CRDT_MAX
- CRDT_MAX, 16, per-channel credit ceiling; must be < 2**CNT_BITS

Ports (clock: one clock; reset is synchronous and active-high):
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- en  in  1  grant enable; 0 blocks new grants, credit returns still counted
- req_vld  in  N_CH  per-requester beat valid
- req_data  in  N_CH*DATA_BITS  per-requester beat; slice i belongs to requester i
- req_rdy  out  N_CH  one-hot pop strobe; bit i = beat i consumed this cycle
- tl_tdata  out  DATA_BITS  transmitted beat
- tl_tvld  out  1  transmit valid
- tl_tch  out  CH_BITS  channel of the transmitted beat
- tl_crdt  in  1  credit return pulse, one credit per cycle
- tl_crdt_ch  in  CH_BITS  channel of the returned credit
- crdt_cnt  out  N_CH*CNT_BITS  current credit count per channel
- crdt_ovf  out  N_CH  sticky; set when a credit is returned to a full channel

## Operation
- Eligibility: eligible[i] = en & req_vld[i] & (cnt[i] != 0).
- Arbitration: round-robin pointer ptr, reset value 0.
  - Grant the first eligible index searching ptr, ptr+1, … mod N_CH.
  - After a grant to g, ptr ← (g+1) mod N_CH. With no grant, ptr holds.
- req_rdy = one-hot grant vector. It is combinational from req_vld, en, the counters and ptr, and is 0 when nothing is eligible.
- Requesters must hold req_vld/req_data stable until popped. A requester may drop req_vld before being granted.
- Counter update each cycle: cnt[i]_next = cnt[i] − dec[i] + inc[i].
  - dec[i] = grant[i].
  - inc[i] = tl_crdt & (tl_crdt_ch == i).
- Simultaneous grant and return on the same channel: the count is unchanged.
- Return with cnt == CRDT_MAX and no same-cycle decrement: the count holds at CRDT_MAX and crdt_ovf[i] is set. It stays set until rst.
- Underflow cannot occur, because a grant requires cnt ≠ 0.
- No FSM beyond reset/run. The block has no state other than counters, ptr, ovf and the output register.

## Timing
- Reset values:
  - tl_tvld=0, tl_tdata=0, tl_tch=0
  - cnt[i]=CRDT_INIT, ptr=0, crdt_ovf=0
  - req_rdy=0 while rst is high
- Grant to output latency is 1 cycle. A grant in cycle t produces, in cycle t+1, tl_tvld=1, tl_tdata=req_data[g] and tl_tch=g.
- The transmit side has no backpressure; credits guarantee acceptance.
- A credit returned in cycle t is visible in crdt_cnt and usable for a grant in cycle t+1.
- Throughput is one beat per cycle across all channels. A single channel with credits and continuous req_vld is granted every cycle when it is the only one eligible.
- rst mid-operation: any beat registered that cycle is dropped (tl_tvld=0 next cycle), counters reload, and credit returns during rst are ignored.
- en falling takes effect the same cycle. A beat granted in the previous cycle still appears on tl_*.

## Structure
- Package dma_pcie_crdt_pkg holds:
  - the N_CH derivation function
  - the ch_t typedef (logic [CH_BITS-1:0])
  - the cnt_t typedef (logic [CNT_BITS-1:0])
  - defaults for CRDT_INIT/CRDT_MAX
- Sub-module dma_pcie_rr_arb: a parameterized N-way round-robin picker. It takes an eligible vector and ptr, and produces a one-hot grant plus the encoded index. It is reusable elsewhere in the DMA.
- Top level holds the counters, ovf flags, ptr update and output register.

## Test plan
- Reset then all four req_vld high, no returns, CRDT_INIT=16 → tl_tch sequence 0,1,2,3 repeating. After 64 beats all crdt_cnt=0 and tl_tvld stays 0.
- Channel 2 only, cnt=1, tl_crdt with tl_crdt_ch=2 in the same cycle as its grant → one beat out and cnt stays 1. The next beat follows immediately.
- Channel 1 at cnt=0 with req_vld high; return one credit in cycle t → req_rdy[1]=1 in t+1 and tl_tvld/tl_tch=1 in t+2.
- Channel 3 at CRDT_MAX=16, return a credit with no grant → cnt stays 16 and crdt_ovf[3]=1, persisting until rst.
- en=0 with all requesters valid for 10 cycles while 5 credits are returned on channel 0 → no req_rdy and no tl_tvld; crdt_cnt[0] shows min(init+5, CRDT_MAX).
- Assert rst for 1 cycle during continuous traffic → next-cycle tl_tvld=0, counters equal CRDT_INIT, and the first post-reset grant goes to channel 0.

Source files
------------

// File: rtl/dma_pcie_crdt_arb_pkg.sv
// Shared types, defaults and helpers for the DMA-to-PCIe credit arbiter.
package dma_pcie_crdt_pkg;

    localparam int CH_BITS_DEF   = 2;
    localparam int CNT_BITS_DEF  = 8;
    localparam int CRDT_INIT_DEF = 16;
    localparam int CRDT_MAX_DEF  = 16;

    typedef logic [CH_BITS_DEF-1:0]  ch_t;
    typedef logic [CNT_BITS_DEF-1:0] cnt_t;

    function automatic int n_ch(input int ch_bits);
        return 1 << ch_bits;
    endfunction

endpackage

// File: rtl/dma_pcie_crdt_arb_if.sv
// Requester, transmit and credit-return signals of the arbiter.
// master = arbiter view, slave = requester/link view.
interface dma_pcie_crdt_arb_if #(
    parameter int DATA_BITS = 512,
    parameter int CH_BITS   = 2,
    parameter int CNT_BITS  = 8
);
    localparam int N_CH = dma_pcie_crdt_pkg::n_ch(CH_BITS);

    logic                      en;
    logic [N_CH-1:0]           req_vld;
    logic [N_CH*DATA_BITS-1:0] req_data;
    logic [N_CH-1:0]           req_rdy;
    logic [DATA_BITS-1:0]      tl_tdata;
    logic                      tl_tvld;
    logic [CH_BITS-1:0]        tl_tch;
    logic                      tl_crdt;
    logic [CH_BITS-1:0]        tl_crdt_ch;
    logic [N_CH*CNT_BITS-1:0]  crdt_cnt;
    logic [N_CH-1:0]           crdt_ovf;

    modport master (
        input  en, req_vld, req_data, tl_crdt, tl_crdt_ch,
        output req_rdy, tl_tdata, tl_tvld, tl_tch, crdt_cnt, crdt_ovf
    );

    modport slave (
        output en, req_vld, req_data, tl_crdt, tl_crdt_ch,
        input  req_rdy, tl_tdata, tl_tvld, tl_tch, crdt_cnt, crdt_ovf
    );

endinterface

// File: rtl/dma_pcie_crdt_arb_rr_arb.sv
// N-way round-robin picker: first eligible index at or after ptr, wrapping mod N.
module dma_pcie_rr_arb #(
    parameter int N        = 4,
    parameter int IDX_BITS = 2
) (
    input  logic [N-1:0]        elig_i,
    input  logic [IDX_BITS-1:0] ptr_i,
    output logic [N-1:0]        gnt_o,
    output logic [IDX_BITS-1:0] idx_o,
    output logic                vld_o
);

    always_comb begin
        int j;
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!vld_o && elig_i[j]) begin
                gnt_o[j] = 1'b1;
                idx_o    = IDX_BITS'(j);
                vld_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_pcie_crdt_arb.sv
// Credit-based round-robin arbiter sharing one DMA-to-PCIe transmit channel.
// Holds per-channel credit counters, sticky overflow flags, the RR pointer and the output beat register.
module dma_pcie_crdt_arb
    import dma_pcie_crdt_pkg::*;
#(
    parameter int DATA_BITS = 512,
    parameter int CH_BITS   = CH_BITS_DEF,
    parameter int CNT_BITS  = CNT_BITS_DEF,
    parameter int CRDT_INIT = CRDT_INIT_DEF,
    parameter int CRDT_MAX  = CRDT_MAX_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    dma_pcie_crdt_arb_if.master  bus
);

    localparam int N_CH = n_ch(CH_BITS);

    logic [CNT_BITS-1:0]  cnt_q [N_CH];
    logic [CNT_BITS-1:0]  cnt_d [N_CH];
    logic [N_CH-1:0]      ovf_q, ovf_d;
    logic [CH_BITS-1:0]   ptr_q, ptr_d;
    logic [N_CH-1:0]      elig, gnt;
    logic [CH_BITS-1:0]   gidx;
    logic                 gvld;
    logic                 tvld_q;
    logic [CH_BITS-1:0]   tch_q;
    logic [DATA_BITS-1:0] tdata_q;

    // Grants are masked during reset so req_rdy never pops a beat that would be dropped.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N_CH; i++) begin
            elig[i] = !rst && bus.en && bus.req_vld[i] && (cnt_q[i] != '0);
        end
    end

    dma_pcie_rr_arb #(
        .N        (N_CH),
        .IDX_BITS (CH_BITS)
    ) u_rr_arb (
        .elig_i (elig),
        .ptr_i  (ptr_q),
        .gnt_o  (gnt),
        .idx_o  (gidx),
        .vld_o  (gvld)
    );

    assign bus.req_rdy = gnt;

    // A grant and a return on the same channel cancel; a return into a full counter only flags overflow.
    always_comb begin
        logic inc;
        inc   = 1'b0;
        ovf_d = ovf_q;
        for (int i = 0; i < N_CH; i++) begin
            inc      = bus.tl_crdt && (bus.tl_crdt_ch == CH_BITS'(i));
            cnt_d[i] = cnt_q[i];
            if (gnt[i] && !inc) begin
                cnt_d[i] = cnt_q[i] - CNT_BITS'(1);
            end else if (inc && !gnt[i]) begin
                if (cnt_q[i] == CNT_BITS'(CRDT_MAX)) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_BITS'(1);
                end
            end
        end
        ptr_d = gvld ? CH_BITS'(gidx + CH_BITS'(1)) : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= CNT_BITS'(CRDT_INIT);
            end
            ovf_q   <= '0;
            ptr_q   <= '0;
            tvld_q  <= 1'b0;
            tch_q   <= '0;
            tdata_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            ptr_q  <= ptr_d;
            tvld_q <= gvld;
            if (gvld) begin
                tch_q   <= gidx;
                tdata_q <= bus.req_data[int'(gidx)*DATA_BITS +: DATA_BITS];
            end
        end
    end

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_cnt_out
            assign bus.crdt_cnt[i*CNT_BITS +: CNT_BITS] = cnt_q[i];
        end
    endgenerate

    assign bus.crdt_ovf = ovf_q;
    assign bus.tl_tvld  = tvld_q;
    assign bus.tl_tch   = tch_q;
    assign bus.tl_tdata = tdata_q;

endmodule

// File: tb/tb_dma_pcie_crdt_arb.sv
// Randomized and directed bench for dma_pcie_crdt_arb against a cycle-level behavioural model.
module tb_dma_pcie_crdt_arb;
    import dma_pcie_crdt_pkg::*;

    localparam int DW   = 64;
    localparam int CHB  = 2;
    localparam int CNTB = 8;
    localparam int NCH  = 4;
    localparam int INIT = 16;
    localparam int MAXC = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dma_pcie_crdt_arb_if #(.DATA_BITS(DW), .CH_BITS(CHB), .CNT_BITS(CNTB)) bus ();

    dma_pcie_crdt_arb #(
        .DATA_BITS (DW),
        .CH_BITS   (CHB),
        .CNT_BITS  (CNTB),
        .CRDT_INIT (INIT),
        .CRDT_MAX  (MAXC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Stimulus state
    logic [NCH-1:0] vld = '0;
    logic [DW-1:0]  rdata [NCH];
    bit             en_r = 1'b0;
    bit             crdt_r = 1'b0;
    int             crdt_ch_r = 0;

    // Behavioural model state
    int             m_cnt [NCH];
    int             m_ptr;
    bit             m_ovf [NCH];
    bit             e_tvld;
    int             e_tch;
    logic [DW-1:0]  e_tdata;

    function automatic int model_pick();
        for (int k = 0; k < NCH; k++) begin
            int j;
            j = (m_ptr + k) % NCH;
            if (!rst && en_r && vld[j] && m_cnt[j] > 0) return j;
        end
        return -1;
    endfunction

    function automatic logic [NCH-1:0] exp_rdy();
        int g;
        logic [NCH-1:0] v;
        g = model_pick();
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    function automatic logic [NCH*CNTB-1:0] m_cnt_vec();
        logic [NCH*CNTB-1:0] v;
        for (int i = 0; i < NCH; i++) v[i*CNTB +: CNTB] = cnt_t'(m_cnt[i]);
        return v;
    endfunction

    function automatic logic [NCH-1:0] m_ovf_vec();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_ovf[i];
        return v;
    endfunction

    task automatic apply();
        bus.en         = en_r;
        bus.req_vld    = vld;
        for (int i = 0; i < NCH; i++) bus.req_data[i*DW +: DW] = rdata[i];
        bus.tl_crdt    = crdt_r;
        bus.tl_crdt_ch = ch_t'(crdt_ch_r);
        #1;
    endtask

    // Advance one clock, update the model from the inputs seen at the edge, refresh popped beats.
    task automatic tick();
        int g;
        g = model_pick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_cnt[i] = INIT;
                m_ovf[i] = 1'b0;
            end
            m_ptr = 0; e_tvld = 1'b0; e_tch = 0; e_tdata = '0;
        end else begin
            e_tvld = (g >= 0);
            if (g >= 0) begin
                e_tch   = g;
                e_tdata = rdata[g];
                m_cnt[g]--;
                m_ptr = (g + 1) % NCH;
            end
            if (crdt_r) begin
                m_cnt[crdt_ch_r]++;
                if (m_cnt[crdt_ch_r] > MAXC) begin
                    m_cnt[crdt_ch_r] = MAXC;
                    m_ovf[crdt_ch_r] = 1'b1;
                end
            end
        end
        if (g >= 0) rdata[g] = {$urandom, $urandom};
        #1;
        apply();
    endtask

    task automatic do_reset();
        rst = 1'b1; crdt_r = 1'b0; vld = '0; en_r = 1'b0;
        apply();
        tick();
        tick();
        rst = 1'b0;
        apply();
    endtask

    task automatic test_reset();
        logic [NCH*CNTB-1:0] all_init;
        all_init = {NCH{cnt_t'(INIT)}};
        rst = 1'b1; en_r = 1'b1; vld = '1; crdt_r = 1'b1; crdt_ch_r = 0;
        apply();
        checks++;
        if (bus.req_rdy !== '0) begin errors++; $display("FAIL reset_rdy got %b exp 0", bus.req_rdy); end
        tick();
        tick();
        checks++;
        if (bus.tl_tvld !== 1'b0) begin errors++; $display("FAIL reset_tvld got %b exp 0", bus.tl_tvld); end
        checks++;
        if (bus.tl_tch !== '0 || bus.tl_tdata !== '0) begin
            errors++; $display("FAIL reset_tch_tdata got %0d/%h exp 0/0", bus.tl_tch, bus.tl_tdata);
        end
        checks++;
        if (bus.crdt_cnt !== all_init) begin errors++; $display("FAIL reset_cnt got %h exp %h", bus.crdt_cnt, all_init); end
        checks++;
        if (bus.crdt_ovf !== '0) begin errors++; $display("FAIL reset_ovf got %b exp 0", bus.crdt_ovf); end
        rst = 1'b0; vld = '0; crdt_r = 1'b0;
        apply();
    endtask

    // All four requesters valid, no returns: 64 beats in channel order 0,1,2,3, then silence.
    task automatic test_rr_drain();
        en_r = 1'b1; vld = '1; crdt_r = 1'b0;
        apply();
        for (int c = 0; c < 70; c++) begin
            checks++;
            if (bus.req_rdy !== exp_rdy()) begin
                errors++; $display("FAIL rr_rdy cyc %0d got %b exp %b", c, bus.req_rdy, exp_rdy());
            end
            tick();
            checks++;
            if (bus.tl_tvld !== (c < 64)) begin
                errors++; $display("FAIL rr_tvld cyc %0d got %b exp %b", c, bus.tl_tvld, (c < 64));
            end
            if (c < 64) begin
                checks++;
                if (bus.tl_tch !== ch_t'(c % NCH) || bus.tl_tdata !== e_tdata) begin
                    errors++; $display("FAIL rr_beat cyc %0d got ch%0d %h exp ch%0d %h",
                                       c, bus.tl_tch, bus.tl_tdata, c % NCH, e_tdata);
                end
            end
        end
        checks++;
        if (bus.crdt_cnt !== '0) begin errors++; $display("FAIL rr_drained_cnt got %h exp 0", bus.crdt_cnt); end
        vld = '0;
        apply();
    endtask

    // Channel 2 at one credit, credit returned in its grant cycle: count holds and the next beat follows.
    task automatic test_same_cycle_return();
        vld = '0; crdt_r = 1'b1; crdt_ch_r = 2;
        apply();
        tick();
        vld = 4'b0100;
        apply();
        checks++;
        if (bus.crdt_cnt[2*CNTB +: CNTB] !== cnt_t'(1)) begin
            errors++; $display("FAIL same_pre_cnt got %0d exp 1", bus.crdt_cnt[2*CNTB +: CNTB]);
        end
        checks++;
        if (bus.req_rdy !== 4'b0100) begin errors++; $display("FAIL same_rdy1 got %b exp 0100", bus.req_rdy); end
        tick();
        checks++;
        if (bus.tl_tvld !== 1'b1 || bus.tl_tch !== ch_t'(2) || bus.crdt_cnt[2*CNTB +: CNTB] !== cnt_t'(1)) begin
            errors++; $display("FAIL same_beat1 got v%b ch%0d cnt%0d exp v1 ch2 cnt1",
                               bus.tl_tvld, bus.tl_tch, bus.crdt_cnt[2*CNTB +: CNTB]);
        end
        crdt_r = 1'b0;
        apply();
        checks++;
        if (bus.req_rdy !== 4'b0100) begin errors++; $display("FAIL same_rdy2 got %b exp 0100", bus.req_rdy); end
        tick();
        checks++;
        if (bus.tl_tvld !== 1'b1 || bus.tl_tch !== ch_t'(2) || bus.tl_tdata !== e_tdata ||
            bus.crdt_cnt[2*CNTB +: CNTB] !== cnt_t'(0)) begin
            errors++; $display("FAIL same_beat2 got v%b ch%0d cnt%0d exp v1 ch2 cnt0",
                               bus.tl_tvld, bus.tl_tch, bus.crdt_cnt[2*CNTB +: CNTB]);
        end
        vld = '0;
        apply();
        tick();
    endtask

    // Channel 1 starved; a credit in cycle t gives req_rdy in t+1 and the beat in t+2.
    task automatic test_zero_credit_return();
        vld = 4'b0010; crdt_r = 1'b1; crdt_ch_r = 1;
        apply();
        checks++;
        if (bus.req_rdy !== '0) begin errors++; $display("FAIL zero_rdy_t got %b exp 0", bus.req_rdy); end
        tick();
        crdt_r = 1'b0;
        apply();
        checks++;
        if (bus.req_rdy !== 4'b0010) begin errors++; $display("FAIL zero_rdy_t1 got %b exp 0010", bus.req_rdy); end
        tick();
        checks++;
        if (bus.tl_tvld !== 1'b1 || bus.tl_tch !== ch_t'(1) || bus.tl_tdata !== e_tdata) begin
            errors++; $display("FAIL zero_beat_t2 got v%b ch%0d exp v1 ch1", bus.tl_tvld, bus.tl_tch);
        end
        vld = '0;
        apply();
        tick();
        checks++;
        if (bus.tl_tvld !== 1'b0) begin errors++; $display("FAIL zero_idle got %b exp 0", bus.tl_tvld); end
    endtask

    // Return into a full channel 3: count saturates, sticky flag set until reset.
    task automatic test_overflow();
        do_reset();
        crdt_r = 1'b1; crdt_ch_r = 3;
        apply();
        tick();
        crdt_r = 1'b0;
        apply();
        checks++;
        if (bus.crdt_cnt[3*CNTB +: CNTB] !== cnt_t'(MAXC) || bus.crdt_ovf !== 4'b1000) begin
            errors++; $display("FAIL ovf_set got cnt%0d ovf%b exp cnt%0d ovf1000",
                               bus.crdt_cnt[3*CNTB +: CNTB], bus.crdt_ovf, MAXC);
        end
        for (int c = 0; c < 5; c++) tick();
        checks++;
        if (bus.crdt_ovf !== 4'b1000) begin errors++; $display("FAIL ovf_sticky got %b exp 1000", bus.crdt_ovf); end
        do_reset();
        checks++;
        if (bus.crdt_ovf !== '0) begin errors++; $display("FAIL ovf_clear got %b exp 0", bus.crdt_ovf); end
    endtask

    // en low blocks grants but credit returns are still counted.
    task automatic test_en_low();
        en_r = 1'b1; vld = 4'b0001; crdt_r = 1'b0;
        apply();
        for (int c = 0; c < 8; c++) tick();
        en_r = 1'b0; vld = '1;
        apply();
        checks++;
        if (bus.tl_tvld !== 1'b1 || bus.tl_tch !== ch_t'(0)) begin
            errors++; $display("FAIL en_prev_beat got v%b ch%0d exp v1 ch0", bus.tl_tvld, bus.tl_tch);
        end
        for (int c = 0; c < 10; c++) begin
            crdt_r = (c < 5); crdt_ch_r = 0;
            apply();
            checks++;
            if (bus.req_rdy !== '0) begin errors++; $display("FAIL en_rdy cyc %0d got %b exp 0", c, bus.req_rdy); end
            tick();
            checks++;
            if (bus.tl_tvld !== 1'b0) begin errors++; $display("FAIL en_tvld cyc %0d got %b exp 0", c, bus.tl_tvld); end
        end
        checks++;
        if (bus.crdt_cnt[0 +: CNTB] !== cnt_t'(13) || bus.crdt_cnt !== m_cnt_vec()) begin
            errors++; $display("FAIL en_cnt got %h exp %h", bus.crdt_cnt, m_cnt_vec());
        end
        crdt_r = 1'b0; vld = '0;
        apply();
    endtask

    // One-cycle reset in the middle of traffic.
    task automatic test_rst_mid();
        do_reset();
        en_r = 1'b1; vld = '1;
        for (int c = 0; c < 12; c++) begin
            crdt_r = $urandom_range(0, 1); crdt_ch_r = $urandom_range(0, NCH-1);
            apply();
            checks++;
            if (bus.req_rdy !== exp_rdy()) begin
                errors++; $display("FAIL rm_rdy cyc %0d got %b exp %b", c, bus.req_rdy, exp_rdy());
            end
            tick();
        end
        rst = 1'b1; crdt_r = 1'b1; crdt_ch_r = 0;
        apply();
        checks++;
        if (bus.req_rdy !== '0) begin errors++; $display("FAIL rm_rdy_rst got %b exp 0", bus.req_rdy); end
        tick();
        checks++;
        if (bus.tl_tvld !== 1'b0 || bus.crdt_cnt !== {NCH{cnt_t'(INIT)}} || bus.crdt_ovf !== '0) begin
            errors++; $display("FAIL rm_after_rst got v%b cnt%h ovf%b exp v0 cnt%h ovf0",
                               bus.tl_tvld, bus.crdt_cnt, bus.crdt_ovf, {NCH{cnt_t'(INIT)}});
        end
        rst = 1'b0; crdt_r = 1'b0;
        apply();
        checks++;
        if (bus.req_rdy !== 4'b0001) begin errors++; $display("FAIL rm_first_rdy got %b exp 0001", bus.req_rdy); end
        tick();
        checks++;
        if (bus.tl_tvld !== 1'b1 || bus.tl_tch !== ch_t'(0)) begin
            errors++; $display("FAIL rm_first_beat got v%b ch%0d exp v1 ch0", bus.tl_tvld, bus.tl_tch);
        end
        vld = '0;
        apply();
    endtask

    // Random traffic, enables and credit returns against the model.
    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            en_r = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < NCH; i++) begin
                if (!vld[i] || $urandom_range(0, 15) == 0) vld[i] = $urandom_range(0, 2) != 0;
            end
            crdt_r = $urandom_range(0, 1); crdt_ch_r = $urandom_range(0, NCH-1);
            apply();
            checks++;
            if (bus.req_rdy !== exp_rdy()) begin
                errors++; $display("FAIL rnd_rdy cyc %0d got %b exp %b", c, bus.req_rdy, exp_rdy());
            end
            tick();
            checks++;
            if (bus.tl_tvld !== e_tvld || (e_tvld && (bus.tl_tch !== ch_t'(e_tch) || bus.tl_tdata !== e_tdata))) begin
                errors++; $display("FAIL rnd_beat cyc %0d got v%b ch%0d %h exp v%b ch%0d %h",
                                   c, bus.tl_tvld, bus.tl_tch, bus.tl_tdata, e_tvld, e_tch, e_tdata);
            end
            checks++;
            if (bus.crdt_cnt !== m_cnt_vec() || bus.crdt_ovf !== m_ovf_vec()) begin
                errors++; $display("FAIL rnd_cnt cyc %0d got %h/%b exp %h/%b",
                                   c, bus.crdt_cnt, bus.crdt_ovf, m_cnt_vec(), m_ovf_vec());
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) begin
            rdata[i] = {$urandom, $urandom};
            m_cnt[i] = INIT;
            m_ovf[i] = 1'b0;
        end
        m_ptr = 0; e_tvld = 1'b0; e_tch = 0; e_tdata = '0;
        apply();
        test_reset();
        test_rr_drain();
        test_same_cycle_return();
        test_zero_credit_return();
        test_overflow();
        test_en_low();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
